// File: rtl/i2c_pkg.sv
// Shared types and constants for the AXI-Stream to I2C write-master slice.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } i2c_state_t;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/axis_i2c_if.sv
// Byte-wide AXI-Stream link between the internal byte source and the I2C master.
interface axis_i2c_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_i2c_master.sv
// AXI-Stream slave to I2C write master: tick divider, 4-phase bit timing and FSM.
import i2c_pkg::*;

module axis_i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  slave_addr,
  axis_i2c_if.slave   s_axis,
  input  logic        sda_line,
  output logic        sda_pull,
  output logic        scl_pull
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  i2c_state_t state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             last_q, last_d;
  logic             nack_q, nack_d;
  logic             got_q, got_d;
  logic             sda_q, sda_d;
  logic             scl_q, scl_d;

  logic       tick;
  logic [7:0] addr_byte;
  logic [7:0] tx_byte;
  logic [2:0] bit_dn;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign addr_byte = {slave_addr, I2C_WRITE};
  assign tx_byte   = (state_q == DATA) ? shreg_q : addr_byte;
  assign bit_dn    = bit_q - 3'd1;
  assign sda_pull  = sda_q;
  assign scl_pull  = scl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      nack_q  <= 1'b0;
      got_q   <= 1'b0;
      sda_q   <= 1'b0;
      scl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      nack_q  <= nack_d;
      got_q   <= got_d;
      sda_q   <= sda_d;
      scl_q   <= scl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    nack_d  = nack_q;
    got_d   = got_q;
    sda_d   = sda_q;
    scl_d   = scl_q;
    div_d   = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);

    // STOP/DONE keep tready high so an aborted transaction drains the source.
    s_axis.tready = (state_q == IDLE) || (state_q == STOP) || (state_q == DONE) ||
                    (state_q == DATA_ACK && phase_q == PH_3 && !nack_q && !last_q && !got_q);

    if (s_axis.tready && s_axis.tvalid && state_q != STOP && state_q != DONE) begin
      shreg_d = s_axis.tdata;
      last_d  = s_axis.tlast;
      if (state_q == IDLE) begin
        state_d = START;
        phase_d = PH_0;
      end else begin
        got_d = 1'b1;
      end
    end

    unique case (state_q)
      START: if (tick) begin
        case (phase_q)
          PH_0: begin sda_d = 1'b1; phase_d = PH_1; end
          PH_1: phase_d = PH_2;
          default: begin
            scl_d   = 1'b1;
            sda_d   = ~addr_byte[7];
            bit_d   = 3'd7;
            phase_d = PH_0;
            state_d = ADDR;
          end
        endcase
      end
      ADDR, ADDR_ACK, DATA, DATA_ACK: if (tick) begin
        case (phase_q)
          PH_0: phase_d = PH_1;
          PH_1: begin phase_d = PH_2; scl_d = 1'b0; end
          PH_2: begin phase_d = PH_3; nack_d = sda_line; end
          default: begin
            case (state_q)
              ADDR, DATA: begin
                scl_d   = 1'b1;
                phase_d = PH_0;
                bit_d   = bit_dn;
                if (bit_q == 3'd0) begin
                  state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                  sda_d   = 1'b0;
                end else begin
                  sda_d = ~tx_byte[bit_dn];
                end
              end
              ADDR_ACK: begin
                scl_d   = 1'b1;
                phase_d = PH_0;
                state_d = nack_q ? STOP : DATA;
                sda_d   = nack_q ? 1'b1 : ~shreg_q[7];
              end
              default: begin
                // Hold SCL high until the next byte has been taken from the stream.
                if (nack_q || (last_q && !got_q)) begin
                  scl_d   = 1'b1;
                  phase_d = PH_0;
                  state_d = STOP;
                  sda_d   = 1'b1;
                end else if (got_q) begin
                  scl_d   = 1'b1;
                  phase_d = PH_0;
                  state_d = DATA;
                  sda_d   = ~shreg_q[7];
                  got_d   = 1'b0;
                end
              end
            endcase
          end
        endcase
      end
      STOP: if (tick) begin
        case (phase_q)
          PH_0: phase_d = PH_1;
          PH_1: begin phase_d = PH_2; scl_d = 1'b0; end
          PH_2: phase_d = PH_3;
          default: begin sda_d = 1'b0; state_d = DONE; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axis_i2c_top.sv
// I2C bus exerciser: inline AXI-Stream byte source feeding axis_i2c_master.
import i2c_pkg::*;

module axis_i2c_top #(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         N_BYTES    = 4,
  parameter logic [7:0] DATA_BASE  = 8'hA0
) (
  input logic clk,
  input logic arstn,
  inout wire  i2c_sda,
  inout wire  i2c_scl
);

  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  axis_i2c_if link ();

  logic [IW-1:0] src_idx;
  logic          src_valid;
  logic          src_done;
  logic          src_last;
  logic          sda_pull;
  logic          scl_pull;

  assign src_last    = (src_idx == IW'(N_BYTES - 1));
  assign link.tvalid = src_valid;
  assign link.tdata  = DATA_BASE + 8'(src_idx);
  assign link.tlast  = src_last;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      src_idx   <= '0;
      src_valid <= 1'b0;
      src_done  <= 1'b0;
    end else if (!src_valid && !src_done) begin
      src_valid <= 1'b1;
    end else if (src_valid && link.tready) begin
      if (src_last) begin
        src_valid <= 1'b0;
        src_done  <= 1'b1;
      end else begin
        src_idx <= src_idx + IW'(1);
      end
    end
  end

  axis_i2c_master #(.CLK_DIV(CLK_DIV)) u_master (
    .clk        (clk),
    .rst        (arstn),
    .slave_addr (SLAVE_ADDR),
    .s_axis     (link),
    .sda_line   (i2c_sda),
    .sda_pull   (sda_pull),
    .scl_pull   (scl_pull)
  );

  assign i2c_sda = sda_pull ? 1'b0 : 1'bz;
  assign i2c_scl = scl_pull ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_axis_i2c_top.sv
// Directed bench for axis_i2c_top: bus monitor plus a configurable ACK/NACK slave model.
module tb_axis_i2c_top;

  localparam int CLK_DIV  = 4;
  localparam int BIT_HALF = 2 * CLK_DIV;

  logic clk   = 1'b0;
  logic arstn = 1'b1;
  logic slave_pull = 1'b0;
  wire  sda;
  wire  scl;

  pullup (sda);
  pullup (scl);
  assign sda = slave_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  axis_i2c_top #(
    .CLK_DIV    (CLK_DIV),
    .SLAVE_ADDR (7'h50),
    .N_BYTES    (4),
    .DATA_BASE  (8'hA0)
  ) dut (
    .clk     (clk),
    .arstn   (arstn),
    .i2c_sda (sda),
    .i2c_scl (scl)
  );

  axis_i2c_if mon ();
  assign mon.tdata  = dut.link.tdata;
  assign mon.tvalid = dut.link.tvalid;
  assign mon.tready = dut.link.tready;
  assign mon.tlast  = dut.link.tlast;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // 0: no slave, 1: ACK everything, 2: NACK the byte at bus index 2
  int unsigned mode = 1;

  logic       psda = 1'b1;
  logic       pscl = 1'b1;
  int         start_cnt, stop_cnt, edge_cnt, rx_n, bitcnt;
  int         hs_cnt, hs_bad, lo_n, hi_n, per_bad, run_len;
  logic       first_fall;
  logic [7:0] rx_sh;
  logic [7:0] rx_byte [8];
  logic       rx_ack  [8];

  initial edge_cnt = 0;

  always @(negedge clk) begin
    psda <= sda;
    pscl <= scl;
    if (arstn) begin
      start_cnt  <= 0;
      stop_cnt   <= 0;
      rx_n       <= 0;
      bitcnt     <= 0;
      hs_cnt     <= 0;
      hs_bad     <= 0;
      lo_n       <= 0;
      hi_n       <= 0;
      per_bad    <= 0;
      run_len    <= 0;
      first_fall <= 1'b1;
      slave_pull <= 1'b0;
    end else begin
      if (sda !== psda || scl !== pscl) edge_cnt <= edge_cnt + 1;
      run_len <= (scl !== pscl) ? 1 : run_len + 1;
      if (mon.tvalid && mon.tready) begin
        if (mon.tdata !== 8'hA0 + 8'(hs_cnt) || mon.tlast !== (hs_cnt == 3)) hs_bad <= hs_bad + 1;
        hs_cnt <= hs_cnt + 1;
      end
      if (pscl && scl && psda && !sda) begin
        start_cnt  <= start_cnt + 1;
        bitcnt     <= 0;
        rx_n       <= 0;
        first_fall <= 1'b1;
        slave_pull <= 1'b0;
      end
      if (pscl && scl && !psda && sda) stop_cnt <= stop_cnt + 1;
      if (!pscl && scl) begin
        lo_n <= lo_n + 1;
        if (run_len != BIT_HALF) per_bad <= per_bad + 1;
        if (bitcnt < 8) begin
          rx_sh  <= {rx_sh[6:0], sda};
          bitcnt <= bitcnt + 1;
        end else begin
          if (rx_n < 8) begin
            rx_byte[rx_n] <= rx_sh;
            rx_ack[rx_n]  <= sda;
          end
          rx_n   <= rx_n + 1;
          bitcnt <= 0;
        end
      end
      if (pscl && !scl) begin
        if (first_fall) first_fall <= 1'b0;
        else begin
          hi_n <= hi_n + 1;
          if (run_len != BIT_HALF) per_bad <= per_bad + 1;
        end
        if (bitcnt == 8) slave_pull <= (mode == 1) || (mode == 2 && rx_n != 2);
        else             slave_pull <= 1'b0;
      end
    end
  end

  task automatic hold_reset();
    int unsigned bad = 0;
    @(negedge clk);
    arstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (sda !== 1'b1 || scl !== 1'b1) bad++;
    end
    chk("reset_lines_idle", bad, 0);
  endtask

  task automatic run_txn(input int unsigned m);
    int unsigned lat, t, e0, n_exp;
    logic [7:0]  exp_b;
    logic        exp_a;
    mode = m;
    @(negedge clk);
    arstn = 1'b0;
    lat = 0;
    while (start_cnt == 0 && lat < 40) begin @(negedge clk); lat++; end
    chk("start_latency_le_10", lat <= 10, 1'b1);
    t = 0;
    while (stop_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
    chk("stop_within_budget", t < 3000, 1'b1);
    e0 = edge_cnt;
    repeat (1000) @(negedge clk);
    chk("quiet_after_stop", edge_cnt - e0, 0);
    chk("start_count", start_cnt, 1);
    chk("stop_count", stop_cnt, 1);
    n_exp = (m == 0) ? 1 : (m == 2) ? 3 : 5;
    chk("byte_count", rx_n, n_exp);
    for (int unsigned i = 0; i < n_exp; i++) begin
      exp_b = (i == 0) ? 8'hA0 : 8'hA0 + 8'(i - 1);
      exp_a = (m == 0) || (m == 2 && i == 2);
      chk($sformatf("m%0d_byte%0d", m, i), rx_byte[i], exp_b);
      chk($sformatf("m%0d_ack%0d", m, i), rx_ack[i], exp_a);
    end
    chk("handshakes", hs_cnt, 4);
    chk("handshake_data", hs_bad, 0);
    if (m == 1) begin
      chk("scl_high_periods", hi_n, 45);
      chk("scl_low_periods", lo_n, 46);
      chk("scl_period_len", per_bad, 0);
    end
  endtask

  initial begin
    int unsigned t;
    hold_reset();
    run_txn(1);
    hold_reset();
    run_txn(0);
    hold_reset();
    run_txn(2);

    hold_reset();
    mode = 1;
    @(negedge clk);
    arstn = 1'b0;
    t = 0;
    while (!(rx_n == 2 && bitcnt == 3) && t < 3000) begin @(negedge clk); t++; end
    chk("mid_txn_reached", t < 3000, 1'b1);
    arstn = 1'b1;
    #1;
    chk("mid_reset_sda", sda, 1'b1);
    chk("mid_reset_scl", scl, 1'b1);
    hold_reset();
    run_txn(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
